// File: rtl/fifo_word_byte_unpacker_if.sv
// rtl/fifo_word_byte_unpacker_if.sv - FIFO read port and byte stream bundle for the word/byte unpacker
interface fifo_word_byte_unpacker_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic [7:0]        byte_data;
  logic              byte_vld;
  logic              byte_rdy;
  logic              byte_last;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              busy;

  modport master (
    output fifo_rd_data, fifo_rd_vld, byte_rdy,
    input  fifo_rd_en, byte_data, byte_vld, byte_last, pkt_cnt, busy
  );

  modport slave (
    input  fifo_rd_data, fifo_rd_vld, byte_rdy,
    output fifo_rd_en, byte_data, byte_vld, byte_last, pkt_cnt, busy
  );
endinterface

// File: rtl/fifo_word_byte_unpacker.sv
// rtl/fifo_word_byte_unpacker.sv - pops FIFO words, emits them as a framed valid/ready byte stream
module fifo_word_byte_unpacker #(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 0,
  parameter int PKT_WORDS  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  fifo_word_byte_unpacker_if.slave   bus
);
  localparam int BYTES  = DATA_W / 8;
  localparam int IDX_W  = $clog2(BYTES);
  localparam int WCNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PKT_WORDS - 1);

  logic [DATA_W-1:0] r_word;
  logic              r_have;
  logic [IDX_W-1:0]  r_idx;
  logic [WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]  r_pkt_cnt;

  logic              w_fire;
  logic              w_last_byte;
  logic              w_pkt_end;
  logic              w_word_done;
  logic              w_pop;
  logic [IDX_W-1:0]  w_sel;
  logic [7:0]        w_byte;

  assign w_last_byte = (r_idx == IDX_LAST);
  assign w_pkt_end   = (r_wcnt == WCNT_LAST);
  assign w_fire      = r_have & bus.byte_rdy;
  assign w_word_done = w_fire & w_last_byte;
  // Reset gates the pop so the FIFO never advances while state is being cleared
  assign w_pop       = bus.fifo_rd_vld & ~rd_rst & (~r_have | w_word_done);
  assign w_sel       = (BIG_ENDIAN != 0) ? (IDX_LAST - r_idx) : r_idx;

  always_comb begin
    w_byte = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (w_sel == IDX_W'(b)) begin
        w_byte = r_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_word    <= '0;
      r_have    <= 1'b0;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_word <= bus.fifo_rd_data;
        r_have <= 1'b1;
        r_idx  <= '0;
      end else if (w_word_done) begin
        r_have <= 1'b0;
      end else if (w_fire) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_word_done) begin
        r_wcnt <= w_pkt_end ? '0 : r_wcnt + WCNT_W'(1);
      end
      if (w_word_done && w_pkt_end) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.fifo_rd_en = w_pop;
  assign bus.byte_data  = w_byte;
  assign bus.byte_vld   = r_have;
  assign bus.byte_last  = r_have & w_last_byte & w_pkt_end;
  assign bus.pkt_cnt    = r_pkt_cnt;
  assign bus.busy       = r_have | (r_wcnt != '0);
endmodule

// File: tb/tb_fifo_word_byte_unpacker.sv
// tb/tb_fifo_word_byte_unpacker.sv - self-checking bench for fifo_word_byte_unpacker
module tb_fifo_word_byte_unpacker;
  localparam int PKT = 4;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       wend;
  } exp_t;

  typedef struct {
    logic       rdy;
    logic       en;
    logic       vld;
    logic [7:0] data;
    logic       last;
  } vec_t;

  logic rd_clk = 1'b0;
  logic rd_rst;
  always #5 rd_clk = ~rd_clk;

  fifo_word_byte_unpacker_if #(.DATA_W(32), .CNT_W(16)) bus_m ();
  fifo_word_byte_unpacker_if #(.DATA_W(32), .CNT_W(16)) bus_b ();
  fifo_word_byte_unpacker_if #(.DATA_W(32), .CNT_W(4))  bus_w ();

  fifo_word_byte_unpacker #(.DATA_W(32), .BIG_ENDIAN(0), .PKT_WORDS(PKT), .CNT_W(16)) dut_m (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .bus(bus_m));
  fifo_word_byte_unpacker #(.DATA_W(32), .BIG_ENDIAN(1), .PKT_WORDS(4), .CNT_W(16)) dut_b (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .bus(bus_b));
  fifo_word_byte_unpacker #(.DATA_W(32), .BIG_ENDIAN(0), .PKT_WORDS(1), .CNT_W(4)) dut_w (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .bus(bus_w));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] fifo_q[$];
  exp_t        sb[$];
  int          tb_wcnt;
  bit          gate;
  bit          prev_stall;
  logic [7:0]  prev_data;
  int          n_pop, n_last, n_fire;
  logic        s_en, s_vld, s_last, s_busy;
  logic [7:0]  s_data;
  bit          bp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  vec_t        le_tab[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    fifo_q.push_back(w);
    for (int b = 0; b < 4; b++) begin
      e.data = w[8*b +: 8];
      e.wend = (b == 3);
      e.last = (b == 3) && (tb_wcnt == PKT - 1);
      sb.push_back(e);
    end
    tb_wcnt = (tb_wcnt == PKT - 1) ? 0 : tb_wcnt + 1;
  endtask

  // One clock of the main DUT: drive at posedge+1, sample at negedge, model the FIFO pop
  task automatic cycle(input bit rdy);
    bit   fire;
    exp_t e;
    bus_m.byte_rdy     = rdy;
    bus_m.fifo_rd_vld  = gate && (fifo_q.size() != 0);
    bus_m.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    @(negedge rd_clk);
    s_en   = bus_m.fifo_rd_en;
    s_vld  = bus_m.byte_vld;
    s_data = bus_m.byte_data;
    s_last = bus_m.byte_last;
    s_busy = bus_m.busy;
    if (prev_stall) begin
      chk("stall_vld_held", s_vld, 1);
      chk("stall_data_held", s_data, prev_data);
    end
    fire = s_vld && rdy;
    if (s_en && s_vld)
      chk("pop_only_on_word_end", fire && (sb.size() != 0) && sb[0].wend, 1);
    if (!s_vld) chk("last_without_vld", s_last, 0);
    if (fire) begin
      n_fire++;
      if (sb.size() == 0) begin
        chk("unexpected_byte", s_data, 8'h00);
        chk("unexpected_byte_fire", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("byte_data", s_data, e.data);
        chk("byte_last", s_last, e.last);
      end
      if (s_last) n_last++;
    end
    if (s_en) begin
      n_pop++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      else chk("pop_from_empty", 1, 0);
    end
    prev_stall = s_vld && !rdy;
    prev_data  = s_data;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic drain(input bit use_bp, input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      cycle(use_bp ? bp[c % 6] : 1'b1);
      c++;
    end
    chk("drain_complete", sb.size() == 0, 1);
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    sb.delete();
    fifo_q.delete();
    tb_wcnt    = 0;
    prev_stall = 0;
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tmp[$];
    logic [7:0]  be_exp[4];
    int          c, pops, lasts;
    bit          done;

    le_tab[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    le_tab[1] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    le_tab[2] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
    le_tab[3] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
    le_tab[4] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b0};
    le_tab[5] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
    le_tab[6] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
    le_tab[7] = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b0};
    le_tab[8] = '{1'b1, 1'b0, 1'b1, 8'h88, 1'b0};
    le_tab[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    be_exp[0] = 8'hA1; be_exp[1] = 8'hB2; be_exp[2] = 8'hC3; be_exp[3] = 8'hD4;

    bus_b.fifo_rd_vld = 0; bus_b.fifo_rd_data = '0; bus_b.byte_rdy = 0;
    bus_w.fifo_rd_vld = 0; bus_w.fifo_rd_data = '0; bus_w.byte_rdy = 0;
    bus_m.byte_rdy = 1;

    // Reset with data already waiting: nothing may be popped while reset is held
    rd_rst = 1'b1;
    tb_wcnt = 0; prev_stall = 0; gate = 1;
    push_word(32'h44332211);
    push_word(32'h88776655);
    bus_m.fifo_rd_vld  = 1;
    bus_m.fifo_rd_data = fifo_q[0];
    repeat (2) @(posedge rd_clk);
    #1;
    chk("rst_byte_vld", bus_m.byte_vld, 0);
    chk("rst_byte_last", bus_m.byte_last, 0);
    chk("rst_byte_data", bus_m.byte_data, 0);
    chk("rst_pkt_cnt", bus_m.pkt_cnt, 0);
    chk("rst_busy", bus_m.busy, 0);
    chk("rst_fifo_rd_en", bus_m.fifo_rd_en, 0);
    rd_rst = 1'b0;

    // Little-endian order and pop timing, cycle by cycle
    n_pop = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(le_tab[i].rdy);
      chk($sformatf("le_en[%0d]", i), s_en, le_tab[i].en);
      chk($sformatf("le_vld[%0d]", i), s_vld, le_tab[i].vld);
      if (le_tab[i].vld) begin
        chk($sformatf("le_data[%0d]", i), s_data, le_tab[i].data);
        chk($sformatf("le_last[%0d]", i), s_last, le_tab[i].last);
      end
    end
    chk("le_pop_count", n_pop, 2);
    chk("le_busy_midpkt", bus_m.busy, 1);

    // Backpressure with bytes 00..1F, continuing the open packet
    for (int i = 0; i < 8; i++)
      push_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    n_last = 0;
    drain(1'b1, 400);
    chk("bp_last_count", n_last, 2);
    chk("bp_pkt_cnt", bus_m.pkt_cnt, 2);

    // Framing over 12 words
    do_reset();
    n_last = 0;
    for (int i = 0; i < 12; i++) push_word($urandom);
    drain(1'b0, 200);
    chk("frame_last_count", n_last, 3);
    chk("frame_pkt_cnt", bus_m.pkt_cnt, 3);
    chk("frame_busy_idle", bus_m.busy, 0);

    // Underflow after word 2 of 4
    push_word($urandom);
    push_word($urandom);
    n_last = 0;
    drain(1'b0, 100);
    gate = 0;
    push_word($urandom);
    push_word($urandom);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      chk($sformatf("gap_vld[%0d]", i), s_vld, 0);
      chk($sformatf("gap_busy[%0d]", i), s_busy, 1);
    end
    gate = 1;
    drain(1'b0, 100);
    chk("underflow_last_count", n_last, 1);
    chk("underflow_pkt_cnt", bus_m.pkt_cnt, 4);

    // Asynchronous reset at idx=2, wcnt=1
    for (int i = 0; i < 4; i++) push_word($urandom);
    n_fire = 0;
    c = 0;
    while (n_fire < 6 && c < 100) begin
      cycle(1'b1);
      c++;
    end
    chk("midrst_reached", n_fire, 6);
    #3;
    rd_rst = 1'b1;
    #1;
    chk("midrst_vld", bus_m.byte_vld, 0);
    chk("midrst_last", bus_m.byte_last, 0);
    chk("midrst_data", bus_m.byte_data, 0);
    chk("midrst_pkt_cnt", bus_m.pkt_cnt, 0);
    chk("midrst_busy", bus_m.busy, 0);
    chk("midrst_rd_en", bus_m.fifo_rd_en, 0);
    tmp = fifo_q;
    fifo_q.delete();
    sb.delete();
    tb_wcnt = 0;
    prev_stall = 0;
    foreach (tmp[i]) push_word(tmp[i]);
    push_word($urandom);
    push_word($urandom);
    @(posedge rd_clk);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    n_last = 0;
    drain(1'b0, 100);
    chk("midrst_last_count", n_last, 1);
    chk("midrst_pkt_cnt_after", bus_m.pkt_cnt, 1);

    // Big-endian instance
    bus_b.fifo_rd_data = 32'hA1B2C3D4;
    bus_b.fifo_rd_vld  = 1;
    bus_b.byte_rdy     = 1;
    @(negedge rd_clk);
    chk("be_pop", bus_b.fifo_rd_en, 1);
    @(posedge rd_clk);
    #1;
    bus_b.fifo_rd_vld = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge rd_clk);
      chk($sformatf("be_vld[%0d]", k), bus_b.byte_vld, 1);
      chk($sformatf("be_data[%0d]", k), bus_b.byte_data, be_exp[k]);
      @(posedge rd_clk);
      #1;
    end

    // Counter wrap: 17 single-word packets into a 4-bit counter
    pops = 0;
    lasts = 0;
    done = 0;
    for (int cc = 0; cc < 200 && !done; cc++) begin
      bus_w.fifo_rd_vld  = (pops < 17);
      bus_w.fifo_rd_data = 32'(pops);
      bus_w.byte_rdy     = 1;
      @(negedge rd_clk);
      if (bus_w.fifo_rd_en) pops++;
      if (bus_w.byte_vld && bus_w.byte_last) lasts++;
      @(posedge rd_clk);
      #1;
      if (pops == 17 && !bus_w.byte_vld) done = 1;
    end
    bus_w.fifo_rd_vld = 0;
    chk("wrap_done", done, 1);
    chk("wrap_pops", pops, 17);
    chk("wrap_lasts", lasts, 17);
    chk("wrap_pkt_cnt", bus_w.pkt_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
